// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from an upstream serial receiver on the falling
// edge of its busy flag and buffers them in a circular FIFO for a consumer.
// An overflow flag records any byte dropped because the buffer was full.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_int,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

    // Storage; contents are never reset, stale data is unreachable via the pointers.
    logic [7:0]    mem_q [DEPTH];

    // rx_int_q is the one-cycle delayed copy of rx_int (rx_int_d).
    logic          rx_int_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;

    logic          wr_req_s;
    logic          empty_s;
    logic          full_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          drop_s;

    // Request/accept decode: write on falling edge of rx_int, reads only when non-empty.
    always_comb begin
        empty_s  = (count_q == {(AW + 1){1'b0}});
        full_s   = (count_q == FULL_CNT);
        wr_req_s = rx_int_q & ~rx_int;
        rd_acc_s = rd_en & ~empty_s;
        wr_acc_s = wr_req_s & (~full_s | rd_en);
        drop_s   = wr_req_s & full_s & ~rd_en;
    end

    // Next-state for pointers, count, read data and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_int_q   <= 1'b0;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW + 1){1'b0}};
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rx_int_q   <= rx_int;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage write; rx_data is sampled in the same cycle as the write request.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign empty    = empty_s;
    assign full     = full_s;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench; bytes expected to be read are queued
// when their frame is driven and compared as rd_valid strobes appear.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_int;
    logic        rd_en;
    logic        clr_ovf;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overflow;

    int          chk_cnt   = 0;
    int          pass_cnt  = 0;
    int          n_valid   = 0;
    int          exp_reads = 0;
    int          mcount    = 0;
    logic        movf      = 1'b0;
    logic [7:0]  sb [$];

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_int   (rx_int),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_count"}, 32'(count), 32'(mcount));
        check_val({tag, "_empty"}, 32'(empty), 32'(mcount == 0));
        check_val({tag, "_full"},  32'(full),  32'(mcount == DEPTH));
        check_val({tag, "_ovf"},   32'(overflow), 32'(movf));
    endtask

    // One frame: rx_int high for two cycles, then falls with byte b presented.
    task automatic send_byte(input logic [7:0] b, input logic rd_same, input logic clr);
        bit wr_ok;
        bit rd_ok;
        rx_int  = 1'b1;
        rx_data = 8'($urandom);
        tick();
        rx_data = 8'($urandom);
        tick();
        rx_data = b;
        rx_int  = 1'b0;
        rd_en   = rd_same;
        clr_ovf = clr;
        wr_ok = (mcount < DEPTH) || rd_same;
        rd_ok = rd_same && (mcount > 0);
        if (rd_ok) exp_reads++;
        if (wr_ok) sb.push_back(b);
        if (wr_ok && !rd_ok) mcount++;
        else if (rd_ok && !wr_ok) mcount--;
        if (!wr_ok) movf = 1'b1;
        else if (clr) movf = 1'b0;
        tick();
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        if (mcount > 0) begin
            exp_reads++;
            mcount--;
        end
        tick();
        rd_en = 1'b0;
    endtask

    // Read-side scoreboard: every rd_valid strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check_val("rd_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                check_val("rd_data", 32'(rd_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_int  = 1'b0;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        #3;
        check_val("rst_rd_data",  32'(rd_data),  32'h00);
        check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_state("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single byte write then read.
        send_byte(8'hA5, 1'b0, 1'b0);
        check_state("single_wr");
        do_read();
        check_val("single_rd_valid", 32'(rd_valid), 32'd1);
        check_val("single_rd_data",  32'(rd_data),  32'hA5);
        check_state("single_rd");
        tick();
        check_val("single_strobe_len", 32'(rd_valid), 32'd0);

        // Fill and wrap.
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
        check_state("fill");
        for (int i = 0; i < 8; i++) do_read();
        for (int i = 16; i < 24; i++) send_byte(8'(i), 1'b0, 1'b0);
        check_state("wrap_full");
        for (int i = 0; i < 16; i++) do_read();
        tick();
        check_state("wrap_drain");

        // Overflow, clear, and set-wins-over-clear.
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b0, 1'b0);
        send_byte(8'hEE, 1'b0, 1'b0);
        check_state("ovf_drop");
        clr_ovf = 1'b1;
        movf = 1'b0;
        tick();
        clr_ovf = 1'b0;
        check_state("ovf_clr");
        send_byte(8'hEF, 1'b0, 1'b1);
        check_state("ovf_set_wins");
        clr_ovf = 1'b1;
        movf = 1'b0;
        tick();
        clr_ovf = 1'b0;

        // Full FIFO: write coincident with read keeps count and sets no overflow.
        send_byte(8'h55, 1'b1, 1'b0);
        check_state("full_simul");
        for (int i = 0; i < 16; i++) do_read();
        tick();
        check_state("full_simul_drain");

        // Empty FIFO: read coincident with write is ignored.
        send_byte(8'h66, 1'b1, 1'b0);
        check_val("empty_simul_rd_valid", 32'(rd_valid), 32'd0);
        check_state("empty_simul");
        do_read();
        tick();

        // Reset mid-operation with rx_int high.
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b0, 1'b0);
        check_state("pre_rst");
        rx_int = 1'b1;
        tick();
        rst = 1'b1;
        #2;
        mcount = 0;
        movf   = 1'b0;
        sb.delete();
        check_state("mid_rst");
        check_val("mid_rst_rd_data", 32'(rd_data), 32'h00);
        tick();
        rst = 1'b0;
        tick();
        tick();
        rx_data = 8'h77;
        rx_int  = 1'b0;
        sb.push_back(8'h77);
        mcount = 1;
        tick();
        check_state("post_rst_wr");
        do_read();
        tick();

        // Edge filtering: long high then long low with data toggling.
        rx_int = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rx_data = 8'($urandom);
            tick();
        end
        check_state("hold_high");
        rx_data = 8'h99;
        rx_int  = 1'b0;
        sb.push_back(8'h99);
        mcount = 1;
        tick();
        check_state("fall_edge");
        for (int i = 0; i < 99; i++) begin
            rx_data = 8'($urandom);
            tick();
        end
        check_state("hold_low");
        do_read();
        tick();
        tick();

        check_val("read_strobes", 32'(n_valid), 32'(exp_reads));
        check_val("sb_left", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001: The block SHALL have parameter DEPTH, default 16, FIFO entry count (power of two, 4..256).
REQ-002: The block SHALL have parameter AW, default 4, address width equal to log2(DEPTH).
REQ-003: Port clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004: Port rst  input  1  asynchronous, active-high reset.
REQ-005: Port rx_data  input  8  received byte from the upstream serial receiver; valid once rx_int has fallen.
REQ-006: Port rx_int  input  1  upstream receive-busy flag, high while a frame is being received, synchronous to clk.
REQ-007: Port rd_en  input  1  read request from the consumer.
REQ-008: Port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009: Port rd_data  output  8  registered read data.
REQ-010: Port rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-011: Port empty  output  1  high when count is 0.
REQ-012: Port full  output  1  high when count equals DEPTH.
REQ-013: Port count  output  AW+1  number of stored bytes, range 0..DEPTH.
REQ-014: Port overflow  output  1  sticky flag set when a byte is dropped.

Function
REQ-015: The block SHALL register rx_int into rx_int_d each cycle and SHALL define wr_req = rx_int_d & ~rx_int, i.e. the falling edge of rx_int.
REQ-016: On a cycle with wr_req high, the block SHALL sample rx_data in that same cycle. Upstream updates rx_data on the same edge that drops rx_int, so no extra delay is applied.
REQ-017: A rising edge of rx_int, or rx_int held at either level, SHALL NOT generate a write.
REQ-018: Storage SHALL be a DEPTH x 8 circular buffer with AW-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-019: A write SHALL be accepted when wr_req=1 and either full=0, or full=1 with rd_en=1 in the same cycle. An accepted write stores the byte at wr_ptr and advances wr_ptr.
REQ-020: When wr_req=1, full=1 and rd_en=0, the byte SHALL be discarded, overflow SHALL be set, and the pointers and count SHALL stay unchanged.
REQ-021: A read SHALL be accepted when rd_en=1 and empty=0. On acceptance, rd_data <= mem[rd_ptr], rd_ptr advances, and rd_valid pulses high on the next cycle (read latency 1 cycle).
REQ-022: rd_en while empty=1 SHALL be ignored, including when a write occurs in the same cycle. rd_valid stays 0 and rd_data holds its value.
REQ-023: rd_data SHALL hold its last value between reads. rd_valid SHALL be high for exactly one cycle per accepted read.
REQ-024: count update rules:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted, or when neither is.
REQ-025: empty and full SHALL be combinational decodes of the registered count, valid in the same cycle as count.
REQ-026: overflow SHALL remain set until clr_ovf=1. If clr_ovf and a new drop occur in the same cycle, overflow SHALL be 1 (set wins).

Reset
REQ-027: While rst=1, the block SHALL hold the following values, independent of clk:
  - rd_data=8'h00, rd_valid=0, overflow=0, count=0, empty=1, full=0.
  - wr_ptr=0, rd_ptr=0, rx_int_d=0.
REQ-028: Memory contents SHALL NOT need reset. Data written before a reset SHALL be unreachable after it.
REQ-029: Reset asserted mid-frame or mid-read SHALL discard all stored data. With rx_int_d=0 after reset, an rx_int already high at deassertion SHALL produce exactly one write at its later falling edge.

Verification
REQ-030: Single byte: rx_data=8'hA5 with rx_int 1->0 -> count=1 and empty=0 on the next cycle; a following rd_en pulse -> rd_valid=1 with rd_data=8'hA5 one cycle later, then count=0 and empty=1.
REQ-031: Fill and wrap: write 0x00..0x0F (16 frames) -> full=1, count=16; read 8, write 0x10..0x17, read 16 -> data in order 0x08..0x17, no overflow.
REQ-032: Overflow: with the FIFO full, write 0xEE with rd_en=0 -> overflow=1, count=16, and 0xEE is never read. clr_ovf=1 -> overflow=0 next cycle.
REQ-033: Simultaneous events:
  - Full FIFO, falling rx_int coincident with rd_en -> count stays 16, no overflow, new byte read last.
  - Empty FIFO, rd_en coincident with a write -> rd_valid=0, count=1.
REQ-034: Reset mid-operation: with 5 bytes stored, assert rst for 1 cycle while rx_int=1 -> count=0 and empty=1 immediately; the later rx_int fall -> exactly one write, count=1.
REQ-035: Edge filtering: rx_int held high for 100 cycles, then low for 100 cycles, with rx_data toggling throughout -> exactly one write, occurring at the falling edge.
